// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, taken-branch flush,
// whole-pipeline freeze on memory busy with deferred flush, freeze timeout
// detection and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int FREEZE_MAX = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_i,
  input  logic [4:0]       ID_rs2_i,
  input  logic             ID_uses_rs2_i,
  input  logic [4:0]       EX_rd_i,
  input  logic             EX_MemRead_i,
  input  logic             Branch_taken_i,
  input  logic             Mem_busy_i,
  output logic             Stall_o,
  output logic             Flush_o,
  output logic             PC_write_o,
  output logic             IDEX_bubble_o,
  output logic             Pipe_freeze_o,
  output logic             Err_o,
  output logic [CNT_W-1:0] Stall_cnt_o,
  output logic [CNT_W-1:0] Flush_cnt_o
);

  // One spare bit so that the freeze count plus one never wraps.
  localparam int FW = $clog2(FREEZE_MAX + 1) + 1;
  localparam logic [FW-1:0] FMAX = FW'(FREEZE_MAX);

  typedef enum logic {RUN, FREEZE} state_t;

  state_t          state_q, state_d;
  logic            flush_pend_q, flush_pend_d;
  logic [FW-1:0]   fcnt_q, fcnt_d, fcnt_inc;
  logic            err_q, err_d, err_now;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic br_ok;

  // Load-use hazard against the load in EX; x0 never creates a dependency.
  assign lu = EX_MemRead_i && (EX_rd_i != 5'd0) &&
              ((EX_rd_i == ID_rs1_i) || (ID_uses_rs2_i && (EX_rd_i == ID_rs2_i)));

  // A branch outcome is only trusted when its operands are not waiting on a load.
  assign br_ok = Branch_taken_i && !lu;

  // Pipeline control outputs and FSM next state, all effective at the coming edge.
  always_comb begin
    state_d       = state_q;
    flush_pend_d  = flush_pend_q;
    Stall_o       = 1'b0;
    Flush_o       = 1'b0;
    PC_write_o    = 1'b1;
    IDEX_bubble_o = 1'b0;
    Pipe_freeze_o = 1'b0;
    if (rst_i) begin
      // Reset zeroes IF/ID and bubbles ID/EX so nothing stale issues.
      Flush_o       = 1'b1;
      PC_write_o    = 1'b0;
      IDEX_bubble_o = 1'b1;
      state_d       = RUN;
      flush_pend_d  = 1'b0;
    end else if (Mem_busy_i) begin
      Pipe_freeze_o = 1'b1;
      Stall_o       = 1'b1;
      PC_write_o    = 1'b0;
      state_d       = FREEZE;
      // Remember a taken branch seen while frozen; apply it on the way out.
      flush_pend_d  = (state_q == FREEZE) ? (flush_pend_q || br_ok) : br_ok;
    end else begin
      state_d      = RUN;
      flush_pend_d = 1'b0;
      if (((state_q == FREEZE) && flush_pend_q) || br_ok) begin
        Flush_o = 1'b1;
      end else if (lu) begin
        Stall_o       = 1'b1;
        PC_write_o    = 1'b0;
        IDEX_bubble_o = 1'b1;
      end
    end
  end

  // Freeze length tracking: fcnt_q holds completed busy cycles of the current
  // freeze, so the busy cycle numbered FREEZE_MAX raises the error.
  always_comb begin
    fcnt_inc = fcnt_q + FW'(1);
    err_now  = Mem_busy_i && (fcnt_inc >= FMAX);
    fcnt_d   = Mem_busy_i ? ((fcnt_q >= FMAX) ? FMAX : fcnt_inc) : '0;
    err_d    = err_q || err_now;
  end

  assign Err_o = !rst_i && (err_q || err_now);

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Stall_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (Flush_o && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign Stall_cnt_o = stall_cnt_q;
  assign Flush_cnt_o = flush_cnt_q;

  // State registers; reset discards any pending flush and all statistics.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      fcnt_q       <= '0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      fcnt_q       <= fcnt_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: width of the stall and flush performance counters.
REQ-002 The block SHALL have parameter FREEZE_MAX, default 255: longest legal memory-freeze length in cycles.
REQ-003 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 ID_rs1_i / ID_rs2_i  in  5 each  source registers of the instruction in ID.
REQ-006 ID_uses_rs2_i  in  1  the ID instruction reads rs2.
REQ-007 EX_rd_i  in  5  destination register of the instruction in EX.
REQ-008 EX_MemRead_i  in  1  the EX instruction is a load.
REQ-009 Branch_taken_i  in  1  branch resolved taken in ID this cycle.
REQ-010 Mem_busy_i  in  1  data memory is not ready; whole pipeline must hold.
REQ-011 Stall_o  out  1  drives the IF/ID Stall input (hold).
REQ-012 Flush_o  out  1  drives the IF/ID Flush input (zero).
REQ-013 PC_write_o  out  1  PC update enable.
REQ-014 IDEX_bubble_o  out  1  zeroes the control fields entering ID/EX.
REQ-015 Pipe_freeze_o  out  1  holds ID/EX, EX/MEM and MEM/WB.
REQ-016 Err_o  out  1  sticky freeze-timeout flag.
REQ-017 Stall_cnt_o / Flush_cnt_o  out  CNT_W each  performance counters.

Function
REQ-018 Load-use hazard (LU) SHALL be EX_MemRead_i & EX_rd_i!=0 & (EX_rd_i==ID_rs1_i | (ID_uses_rs2_i & EX_rd_i==ID_rs2_i)), combinational.
REQ-019 FSM states SHALL be RUN and FREEZE; a flush_pend register SHALL also be kept.
REQ-020 Outputs SHALL be combinational from state, flush_pend and inputs, so that they take effect at the same clock edge.
REQ-021 RUN, Mem_busy_i=1: Pipe_freeze_o=1, Stall_o=1, PC_write_o=0, Flush_o=0, IDEX_bubble_o=0; next state FREEZE; flush_pend <= Branch_taken_i & ~LU.
REQ-022 RUN, no busy, LU=1: Stall_o=1, PC_write_o=0, IDEX_bubble_o=1, Flush_o=0; Branch_taken_i SHALL be ignored (branch operands are not valid).
REQ-023 RUN, no busy, LU=0, Branch_taken_i=1: Flush_o=1, Stall_o=0, PC_write_o=1, IDEX_bubble_o=0.
REQ-024 RUN, no busy, LU=0, Branch_taken_i=0: Stall_o=0, Flush_o=0, PC_write_o=1, IDEX_bubble_o=0, Pipe_freeze_o=0.
REQ-025 FREEZE, Mem_busy_i=1: outputs as in REQ-021; flush_pend <= flush_pend | (Branch_taken_i & ~LU).
REQ-026 FREEZE, Mem_busy_i=0: next state RUN; if flush_pend | (Branch_taken_i & ~LU), then Flush_o=1, PC_write_o=1 and flush_pend is cleared; otherwise REQ-022/REQ-024 apply.
REQ-027 Stall_o and Flush_o SHALL never both be 1 in any cycle.
REQ-028 A freeze-length counter SHALL count consecutive FREEZE cycles with Mem_busy_i=1.
REQ-029 When the freeze-length counter reaches FREEZE_MAX, Err_o SHALL go to 1 and stay 1 until reset; the counter SHALL saturate at FREEZE_MAX.
REQ-030 Stall_cnt_o SHALL increment on each cycle with Stall_o=1, saturating at all-ones.
REQ-031 Flush_cnt_o SHALL increment on each cycle with Flush_o=1, saturating at all-ones.

Reset
REQ-032 While rst_i=1, the block SHALL force: state RUN, flush_pend 0, freeze counter 0, Err_o 0, both performance counters 0.
REQ-033 While rst_i=1, outputs SHALL be Flush_o=1, Stall_o=0, PC_write_o=0, IDEX_bubble_o=1, Pipe_freeze_o=0.
REQ-034 Reset asserted during FREEZE SHALL discard flush_pend; the first cycle after release SHALL be RUN.

Verification
REQ-035 Load-use: EX_MemRead=1, EX_rd=5, ID_rs1=5 -> Stall_o=1, PC_write_o=0, IDEX_bubble_o=1 for 1 cycle; Stall_cnt_o=1.
REQ-036 x0 and no rs2 use: EX_rd=0, rs1=0 -> no stall. EX_rd=7, rs2=7, ID_uses_rs2=0 -> no stall.
REQ-037 LU and Branch_taken in the same cycle -> Stall_o=1, Flush_o=0; Flush_cnt_o unchanged.
REQ-038 Mem_busy for 3 cycles, Branch_taken pulsed in the 1st busy cycle only -> Stall_o=1 for 3 cycles, then Flush_o=1 for exactly 1 cycle on the first non-busy cycle.
REQ-039 FREEZE_MAX=4, Mem_busy held 6 cycles -> Err_o rises in the 4th busy cycle and stays 1 after busy drops; rst_i pulse -> Err_o=0, counters 0.
REQ-040 Asynchronous rst_i mid-freeze with flush_pend=1 -> outputs per REQ-033 immediately; after release with no busy or branch -> Flush_o=0.
